spm_dma: RTL and testbench
==========================

SPM_DMA -- requirements
Module: spm_dma

Interface
REQ-001 The parameter list SHALL be: ADDR_W, 12, SPM word-address width.
REQ-002 The parameter list SHALL include: DATA_W, 32, word width.
REQ-003 The parameter list SHALL include: OUT_DEPTH, 2, read-side buffer depth in words (minimum 2).
REQ-004 The block SHALL have one clock and a synchronous, active-low reset; ports SHALL be:
  cpu_clk  in  1  clock
  cpu_rst_n  in  1  synchronous active-low reset
  cmd_start  in  1  start pulse, sampled only in IDLE
  cmd_dir  in  1  0 = stream-to-SPM write, 1 = SPM-to-stream read
  cmd_addr  in  12  first SPM word address
  cmd_len  in  13  word count 0..4096
  busy  out  1  transfer in progress
  done  out  1  one-cycle completion pulse
  in_valid/in_ready  in/out  1  write-stream handshake
  in_data  in  32  write-stream data
  out_valid/out_ready  out/in  1  read-stream handshake
  out_data  out  32  read-stream data
  if_mem_asn  out  1  SPM strobe, 0 = enable
  if_mem_rw  out  1  0 = write, 1 = read
  if_mem_addr  out  12  SPM word address
  if_mem_wdata  out  32  SPM write data
  if_mem_rdata  in  32  SPM read data, valid 1 cycle after read strobe

Function
REQ-005 FSM states SHALL be IDLE, WR, RD, FIN.
REQ-006 In IDLE, cmd_start=1 SHALL latch addr/len/dir and enter WR (dir 0) or RD (dir 1); cmd_len=0 SHALL enter FIN directly, with no SPM access.
REQ-007 cmd_start SHALL be ignored outside IDLE.
REQ-008 busy SHALL be 1 in WR, RD and FIN, else 0.
REQ-009 WR: in_ready=1 while words remain; each in_valid&in_ready cycle SHALL drive if_mem_asn=0, if_mem_rw=0, if_mem_addr=pointer, if_mem_wdata=in_data combinationally, then increment pointer and decrement remaining.
REQ-010 RD: a read SHALL be issued (if_mem_asn=0, if_mem_rw=1) in any cycle where words remain to be issued and buffered + in-flight words < OUT_DEPTH; the if_mem_rdata of the following cycle SHALL be pushed into the buffer.
REQ-011 out_valid SHALL equal buffer non-empty; out_data SHALL be the buffer head, in address order.
REQ-012 Sustained throughput SHALL be 1 word/cycle in both directions with in_valid=1, out_ready=1.
REQ-013 The buffer SHALL hold data stable while out_valid=1 and out_ready=0, and SHALL never overflow.
REQ-014 The pointer SHALL wrap 0xFFF -> 0x000 without error.
REQ-015 WR SHALL go to FIN in the cycle after the last write; RD SHALL go to FIN after the last out handshake, with nothing issued, in flight or buffered.
REQ-016 FIN SHALL assert done for exactly one cycle, then return to IDLE.
REQ-017 Outside WR write cycles and RD issue cycles, if_mem_asn SHALL be 1, if_mem_rw SHALL be 1, and in_ready SHALL be 0.
REQ-018 In RD, in_ready SHALL be 0; in WR, out_valid SHALL be 0.

Reset
REQ-019 On cpu_rst_n=0 at a clock edge: state=IDLE; busy=0; done=0; in_ready=0; out_valid=0; buffer and in-flight flag cleared; pointer=0; remaining=0; if_mem_asn=1; if_mem_rw=1.
REQ-020 Reset mid-transfer SHALL abort it with no done pulse; SPM writes already performed SHALL stand.

Structure
REQ-021 Package spm_dma_pkg SHALL hold ENABLE=0/DISABLE=1 and WRITE=0/READ=1 strobe constants, the FSM state enum, and the ADDR_W/DATA_W defaults.
REQ-022 The read buffer SHALL be the sub-module spm_dma_fifo, a synchronous FIFO of depth OUT_DEPTH.

Verification
REQ-023 Write burst: addr 0x010, len 4, words A0..A3 with in_valid held -> four consecutive write strobes at 0x010..0x013; SPM holds A0..A3; done 1 cycle after the last write.
REQ-024 Read burst with backpressure: preload 0x100..0x107, len 8, out_ready toggling 1/0 -> 8 words in order, no loss or duplicates, at most 2 outstanding, exactly one done.
REQ-025 Wrap: write at addr 0xFFE, len 4 -> accesses to 0xFFE, 0xFFF, 0x000, 0x001.
REQ-026 Zero length and ignored start: cmd_len=0 -> done 1 cycle after start with no strobes; a cmd_start during a busy transfer -> no effect.
REQ-027 Reset mid-read after 3 of 8 words -> all outputs at reset values next cycle, no done; a new 2-word command then completes normally.

Source files
------------

// File: rtl/spm_dma_pkg.sv
// Shared constants and types for the scratchpad-memory DMA engine.
// Strobe polarities match the SPM macro: asn is active-low, rw is 1 for read.
package spm_dma_pkg;

   localparam int DEF_ADDR_W = 12;
   localparam int DEF_DATA_W = 32;

   localparam logic ENABLE  = 1'b0;
   localparam logic DISABLE = 1'b1;
   localparam logic WRITE   = 1'b0;
   localparam logic READ    = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WR   = 2'd1,
      RD   = 2'd2,
      FIN  = 2'd3
   } dma_state_t;

endpackage

// File: rtl/spm_dma_fifo.sv
// Small synchronous FIFO that buffers SPM read data ahead of the output stream.
// The caller guarantees it never pushes when full or pops when empty.
module spm_dma_fifo
   import spm_dma_pkg::*;
#(
   parameter int DEPTH  = 2,
   parameter int DATA_W = DEF_DATA_W,
   parameter int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] head_data,
   output logic              empty,
   output logic [CNT_W-1:0]  count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;

   // Explicit wrap so depths that are not a power of two still work.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= next_ptr(wr_ptr);
         if (pop)  rd_ptr <= next_ptr(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   assign head_data = mem[rd_ptr];
   assign empty     = (count == '0);

endmodule

// File: rtl/spm_dma.sv
// Single-channel DMA between a valid/ready word stream and the scratchpad memory.
// Writes stream into SPM at 1 word/cycle; reads prefetch into a small FIFO.
module spm_dma
   import spm_dma_pkg::*;
#(
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int OUT_DEPTH = 2
) (
   input  logic              cpu_clk,
   input  logic              cpu_rst_n,
   input  logic              cmd_start,
   input  logic              cmd_dir,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [ADDR_W:0]   cmd_len,
   output logic              busy,
   output logic              done,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              if_mem_asn,
   output logic              if_mem_rw,
   output logic [ADDR_W-1:0] if_mem_addr,
   output logic [DATA_W-1:0] if_mem_wdata,
   input  logic [DATA_W-1:0] if_mem_rdata
);

   localparam int LEN_W = ADDR_W + 1;
   localparam int CNT_W = $clog2(OUT_DEPTH + 1);

   dma_state_t        state;
   dma_state_t        next_state;
   logic [ADDR_W-1:0] ptr;
   logic [LEN_W-1:0]  remaining;
   logic              in_flight;
   logic [CNT_W-1:0]  fifo_count;
   logic              fifo_empty;
   logic              wr_fire;
   logic              rd_issue;
   logic              out_fire;
   logic              rd_last;
   int                occupancy;

   assign out_fire = out_valid & out_ready;
   assign wr_fire  = (state == WR) && (remaining != '0) && in_valid;

   // A word leaving the FIFO this cycle frees its slot for the read issued now,
   // which is what lets a depth-2 buffer sustain one word per cycle.
   assign occupancy = int'(fifo_count) + int'(in_flight) - int'(out_fire);
   assign rd_issue  = (state == RD) && (remaining != '0) && (occupancy < OUT_DEPTH);

   assign rd_last = (remaining == '0) && !in_flight &&
                    (fifo_empty || ((fifo_count == CNT_W'(1)) && out_fire));

   always_ff @(posedge cpu_clk) begin
      if (!cpu_rst_n) state <= IDLE;
      else            state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (cmd_start) begin
               if (cmd_len == '0)        next_state = FIN;
               else if (cmd_dir == READ) next_state = RD;
               else                      next_state = WR;
            end
         end
         WR:      if (wr_fire && (remaining == LEN_W'(1))) next_state = FIN;
         RD:      if (rd_last) next_state = FIN;
         FIN:     next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      busy       = (state != IDLE);
      done       = (state == FIN);
      in_ready   = (state == WR) && (remaining != '0);
      if_mem_asn = DISABLE;
      if_mem_rw  = READ;
      if (wr_fire) begin
         if_mem_asn = ENABLE;
         if_mem_rw  = WRITE;
      end else if (rd_issue) begin
         if_mem_asn = ENABLE;
         if_mem_rw  = READ;
      end
   end

   // In RD, remaining counts words still to be issued, not words still to be delivered.
   always_ff @(posedge cpu_clk) begin
      if (!cpu_rst_n) begin
         ptr       <= '0;
         remaining <= '0;
         in_flight <= 1'b0;
      end else begin
         in_flight <= rd_issue;
         if ((state == IDLE) && cmd_start) begin
            ptr       <= cmd_addr;
            remaining <= cmd_len;
         end else if (wr_fire || rd_issue) begin
            ptr       <= ptr + 1'b1;
            remaining <= remaining - 1'b1;
         end
      end
   end

   assign if_mem_addr  = ptr;
   assign if_mem_wdata = in_data;
   assign out_valid    = !fifo_empty;

   spm_dma_fifo #(
      .DEPTH  (OUT_DEPTH),
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
   ) u_out_fifo (
      .clk       (cpu_clk),
      .rst_n     (cpu_rst_n),
      .push      (in_flight),
      .push_data (if_mem_rdata),
      .pop       (out_fire),
      .head_data (out_data),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

endmodule

// File: tb/tb_spm_dma.sv
// Directed bench for spm_dma: table of per-cycle write/zero-length/wrap vectors,
// then hand sequences for a back-pressured read burst and a mid-read reset.
module tb_spm_dma;
   import spm_dma_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_start;
   logic        cmd_dir;
   logic [11:0] cmd_addr;
   logic [12:0] cmd_len;
   logic        busy;
   logic        done;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        if_mem_asn;
   logic        if_mem_rw;
   logic [11:0] if_mem_addr;
   logic [31:0] if_mem_wdata;
   logic [31:0] if_mem_rdata;

   logic [31:0] spm_mem [4096];
   logic        pre_en;
   logic [11:0] pre_addr;
   logic [31:0] pre_data;

   int total = 0;
   int bad = 0;
   int rd_cnt = 0;
   int wr_cnt = 0;
   int done_cnt = 0;
   int taken_cnt = 0;
   int dropped = 0;
   int max_os = 0;

   typedef struct {
      logic        start;
      logic        dir;
      logic [11:0] addr;
      logic [12:0] len;
      logic        iv;
      logic [31:0] idata;
      logic        busy;
      logic        done;
      logic        irdy;
      logic        asn;
      logic        rw;
      logic [11:0] maddr;
   } vec_t;

   vec_t tbl [18];

   always #5 clk = ~clk;

   spm_dma #(.ADDR_W(12), .DATA_W(32), .OUT_DEPTH(2)) dut (
      .cpu_clk      (clk),
      .cpu_rst_n    (rst_n),
      .cmd_start    (cmd_start),
      .cmd_dir      (cmd_dir),
      .cmd_addr     (cmd_addr),
      .cmd_len      (cmd_len),
      .busy         (busy),
      .done         (done),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .if_mem_asn   (if_mem_asn),
      .if_mem_rw    (if_mem_rw),
      .if_mem_addr  (if_mem_addr),
      .if_mem_wdata (if_mem_wdata),
      .if_mem_rdata (if_mem_rdata)
   );

   // SPM model plus event counters; outstanding = reads issued but not yet handed out.
   always @(posedge clk) begin
      if (pre_en) spm_mem[pre_addr] <= pre_data;
      if (!rst_n) begin
         dropped = rd_cnt - taken_cnt;
      end else begin
         if (if_mem_asn == ENABLE) begin
            if (if_mem_rw == READ) begin
               if_mem_rdata <= spm_mem[if_mem_addr];
               rd_cnt++;
            end else begin
               spm_mem[if_mem_addr] <= if_mem_wdata;
               wr_cnt++;
            end
         end
         if (done) done_cnt++;
         if (out_valid && out_ready) taken_cnt++;
         if (rd_cnt - taken_cnt - dropped > max_os) max_os = rd_cnt - taken_cnt - dropped;
      end
   end

   function automatic vec_t mk(input logic s, input logic d, input logic [11:0] a,
                               input logic [12:0] l, input logic iv, input logic [31:0] id,
                               input logic b, input logic dn, input logic ir,
                               input logic asn, input logic rw, input logic [11:0] ma);
      vec_t v;
      v.start = s;  v.dir = d;   v.addr = a;  v.len = l;
      v.iv = iv;    v.idata = id; v.busy = b; v.done = dn;
      v.irdy = ir;  v.asn = asn; v.rw = rw;   v.maddr = ma;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      cmd_start = v.start;
      cmd_dir   = v.dir;
      cmd_addr  = v.addr;
      cmd_len   = v.len;
      in_valid  = v.iv;
      in_data   = v.idata;
      out_ready = 1'b0;
   endtask

   task automatic checkIdleOutputs(input string tag);
      checkOutput({tag, " busy"},      32'(busy), 32'd0);
      checkOutput({tag, " done"},      32'(done), 32'd0);
      checkOutput({tag, " in_ready"},  32'(in_ready), 32'd0);
      checkOutput({tag, " out_valid"}, 32'(out_valid), 32'd0);
      checkOutput({tag, " asn"},       32'(if_mem_asn), 32'd1);
      checkOutput({tag, " rw"},        32'(if_mem_rw), 32'd1);
   endtask

   task automatic preloadRange(input logic [11:0] a, input logic [31:0] d, input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         pre_en   = 1'b1;
         pre_addr = a + 12'(k);
         pre_data = d + 32'(k);
      end
      @(negedge clk);
      pre_en = 1'b0;
   endtask

   task automatic runRead(input logic [11:0] a, input int len, input bit toggle, input logic [31:0] base);
      int got = 0;
      int cyc = 0;
      int d0 = done_cnt;
      int w0 = wr_cnt;
      @(negedge clk);
      cmd_start = 1'b1; cmd_dir = READ; cmd_addr = a; cmd_len = 13'(len); out_ready = 1'b0;
      @(negedge clk);
      cmd_start = 1'b0;
      while (done_cnt == d0 && cyc < 200) begin
         out_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
         #1;
         checkOutput("rd in_ready", 32'(in_ready), 32'd0);
         if (out_valid && out_ready) begin
            checkOutput($sformatf("rd word%0d", got), out_data, base + 32'(got));
            got++;
         end
         @(negedge clk);
         cyc++;
      end
      out_ready = 1'b0;
      checkOutput("rd no timeout", 32'(cyc < 200), 32'd1);
      checkOutput("rd word count", 32'(got), 32'(len));
      repeat (3) @(negedge clk);
      #1;
      checkOutput("rd done pulses", 32'(done_cnt - d0), 32'd1);
      checkOutput("rd busy after", 32'(busy), 32'd0);
      checkOutput("rd no writes", 32'(wr_cnt - w0), 32'd0);
   endtask

   initial begin
      int cyc;
      int d0;
      int t0;

      tbl[0]  = mk(1, 0, 12'h010, 13'd4, 0, 32'h0,         0, 0, 0, 1, 1, 12'h0);
      tbl[1]  = mk(0, 0, 12'h000, 13'd0, 1, 32'hA000_0000, 1, 0, 1, 0, 0, 12'h010);
      tbl[2]  = mk(1, 1, 12'h500, 13'd7, 1, 32'hA000_0001, 1, 0, 1, 0, 0, 12'h011);
      tbl[3]  = mk(0, 0, 12'h000, 13'd0, 1, 32'hA000_0002, 1, 0, 1, 0, 0, 12'h012);
      tbl[4]  = mk(0, 0, 12'h000, 13'd0, 1, 32'hA000_0003, 1, 0, 1, 0, 0, 12'h013);
      tbl[5]  = mk(0, 0, 12'h000, 13'd0, 0, 32'h0,         1, 1, 0, 1, 1, 12'h0);
      tbl[6]  = mk(0, 0, 12'h000, 13'd0, 0, 32'h0,         0, 0, 0, 1, 1, 12'h0);
      tbl[7]  = mk(1, 0, 12'h020, 13'd0, 0, 32'h0,         0, 0, 0, 1, 1, 12'h0);
      tbl[8]  = mk(0, 0, 12'h000, 13'd0, 1, 32'hDEAD_BEEF, 1, 1, 0, 1, 1, 12'h0);
      tbl[9]  = mk(0, 0, 12'h000, 13'd0, 0, 32'h0,         0, 0, 0, 1, 1, 12'h0);
      tbl[10] = mk(1, 0, 12'hFFE, 13'd4, 0, 32'h0,         0, 0, 0, 1, 1, 12'h0);
      tbl[11] = mk(0, 0, 12'h000, 13'd0, 1, 32'hB0B0_0000, 1, 0, 1, 0, 0, 12'hFFE);
      tbl[12] = mk(0, 0, 12'h000, 13'd0, 0, 32'h0,         1, 0, 1, 1, 1, 12'h0);
      tbl[13] = mk(0, 0, 12'h000, 13'd0, 1, 32'hB0B0_0001, 1, 0, 1, 0, 0, 12'hFFF);
      tbl[14] = mk(0, 0, 12'h000, 13'd0, 1, 32'hB0B0_0002, 1, 0, 1, 0, 0, 12'h000);
      tbl[15] = mk(0, 0, 12'h000, 13'd0, 1, 32'hB0B0_0003, 1, 0, 1, 0, 0, 12'h001);
      tbl[16] = mk(0, 0, 12'h000, 13'd0, 0, 32'h0,         1, 1, 0, 1, 1, 12'h0);
      tbl[17] = mk(0, 0, 12'h000, 13'd0, 0, 32'h0,         0, 0, 0, 1, 1, 12'h0);

      rst_n = 1'b0; cmd_start = 1'b0; cmd_dir = 1'b0; cmd_addr = '0; cmd_len = '0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      pre_en = 1'b0; pre_addr = '0; pre_data = '0;
      repeat (2) @(negedge clk);
      #1;
      checkIdleOutputs("reset");
      rst_n = 1'b1;

      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         applyStimulus(tbl[i]);
         #1;
         checkOutput($sformatf("row%0d busy", i),      32'(busy), 32'(tbl[i].busy));
         checkOutput($sformatf("row%0d done", i),      32'(done), 32'(tbl[i].done));
         checkOutput($sformatf("row%0d in_ready", i),  32'(in_ready), 32'(tbl[i].irdy));
         checkOutput($sformatf("row%0d asn", i),       32'(if_mem_asn), 32'(tbl[i].asn));
         checkOutput($sformatf("row%0d rw", i),        32'(if_mem_rw), 32'(tbl[i].rw));
         checkOutput($sformatf("row%0d out_valid", i), 32'(out_valid), 32'd0);
         if (tbl[i].asn == ENABLE) begin
            checkOutput($sformatf("row%0d addr", i),  32'(if_mem_addr), 32'(tbl[i].maddr));
            checkOutput($sformatf("row%0d wdata", i), if_mem_wdata, tbl[i].idata);
         end
      end
      @(negedge clk);
      applyStimulus(tbl[17]);
      #1;
      for (int k = 0; k < 4; k++) begin
         checkOutput($sformatf("spm burst %0d", k), spm_mem[12'h010 + 12'(k)], 32'hA000_0000 + 32'(k));
         checkOutput($sformatf("spm wrap %0d", k),  spm_mem[12'hFFE + 12'(k)], 32'hB0B0_0000 + 32'(k));
      end
      checkOutput("write strobes", 32'(wr_cnt), 32'd8);
      checkOutput("write done pulses", 32'(done_cnt), 32'd3);

      preloadRange(12'h100, 32'hC000_0000, 8);
      runRead(12'h100, 8, 1'b1, 32'hC000_0000);
      checkOutput("max outstanding le 2", 32'(max_os <= 2), 32'd1);

      preloadRange(12'h200, 32'hD000_0000, 8);
      d0 = done_cnt;
      t0 = taken_cnt;
      @(negedge clk);
      cmd_start = 1'b1; cmd_dir = READ; cmd_addr = 12'h200; cmd_len = 13'd8; out_ready = 1'b1;
      @(negedge clk);
      cmd_start = 1'b0;
      cyc = 0;
      while ((taken_cnt - t0) < 3 && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      checkOutput("pre-reset wait", 32'(cyc < 50), 32'd1);
      rst_n = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      #1;
      checkIdleOutputs("midreset");
      checkOutput("midreset no done", 32'(done_cnt - d0), 32'd0);
      rst_n = 1'b1;
      runRead(12'h200, 2, 1'b0, 32'hD000_0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
